// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : icache_pkg
//  Purpose  : Shared core cache definitions. Holds the controller state
//             encoding, the fixed address/data geometry and a line-base
//             helper. The instruction cache uses it today, and the data
//             cache is expected to reuse it later.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;   // 32-bit words, byte lanes ignored

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DONE   = 2'd2
  } cache_state_e;

  // Field widths of a physical address for a given geometry.
  function automatic int unsigned off_width(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Clears the word-offset and byte bits, giving the first byte address of
  // the line that contains addr.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr,
                                                  input int unsigned       line_bytes);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'(line_bytes - 1);
    return addr & ~mask;
  endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped, register-based instruction cache. A hit returns
//             the word in the same cycle. A miss refills the whole line in
//             word order (0..WORDS-1), one bus request per word, and then
//             spends one DONE cycle before the retried fetch hits.
//  Ports    : clk_i, rst_i (async, active-low)
//             icache_en_i, iphy_addr_i[31:0], invalidate_i  - MMU side
//             icache_data_o[31:0], icache_data_ready_o       - fetch result
//             mem_req_o, mem_addr_o[31:0], mem_data_i[31:0],
//             mem_data_ready_i                               - refill bus
//             busy_o                                         - not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 16,   // power of two, >= 2
  parameter int unsigned WORDS = 4     // power of two, >= 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              icache_en_i,
  input  logic [ADDR_W-1:0] iphy_addr_i,
  input  logic              invalidate_i,
  output logic [DATA_W-1:0] icache_data_o,
  output logic              icache_data_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_data_ready_i,
  output logic              busy_o
);

  localparam int unsigned OFF_W   = off_width(WORDS);
  localparam int unsigned IDX_W   = idx_width(LINES);
  localparam int unsigned IDX_LSB = OFF_W + BYTE_OFF_W;
  localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
  localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
  localparam int unsigned LINE_B  = WORDS * (DATA_W / 8);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  cache_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               inval_pend_q, inval_pend_d;

  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [DATA_W-1:0]  data_q [LINES][WORDS];

  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [OFF_W-1:0]   req_off;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               fill_we, tag_we;

  always_comb begin
    req_idx  = iphy_addr_i[IDX_LSB +: IDX_W];
    req_off  = iphy_addr_i[BYTE_OFF_W +: OFF_W];
    req_tag  = iphy_addr_i[TAG_LSB +: TAG_W];
    fill_idx = base_q[IDX_LSB +: IDX_W];

    hit = (state_q == ST_IDLE) && icache_en_i && valid_q[req_idx]
          && (tag_q[req_idx] == req_tag);

    icache_data_ready_o = hit;
    icache_data_o       = hit ? data_q[req_idx][req_off] : '0;
    mem_req_o           = (state_q == ST_REFILL);
    // base_q has its offset bits cleared, so OR-ing in the word index is an add.
    mem_addr_o          = mem_req_o ? (base_q | ADDR_W'({cnt_q, 2'b00})) : '0;
    busy_o              = (state_q != ST_IDLE);

    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    inval_pend_d = inval_pend_q;
    fill_we      = 1'b0;
    tag_we       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (icache_en_i && !hit) begin
          base_d       = line_base(iphy_addr_i, LINE_B);
          cnt_d        = '0;
          inval_pend_d = 1'b0;
          state_d      = ST_REFILL;
        end
      end
      ST_REFILL: begin
        // An invalidate seen at any point of the refill must keep the line
        // that is being filled from becoming valid at the end.
        if (invalidate_i) inval_pend_d = 1'b1;
        if (mem_data_ready_i) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) begin
            tag_we = 1'b1;
            if (!(inval_pend_q || invalidate_i)) valid_d[fill_idx] = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (invalidate_i) valid_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      inval_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      inval_pend_q <= inval_pend_d;
    end
  end

  // Tag and data storage carry no reset; valid_q alone decides a hit.
  always_ff @(posedge clk_i) begin
    if (fill_we) data_q[fill_idx][cnt_q] <= mem_data_i;
    if (tag_we)  tag_q[fill_idx]         <= base_q[TAG_LSB +: TAG_W];
  end

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache
//  Purpose  : Directed self-checking bench for icache (default geometry:
//             16 lines x 4 words). Memory contents come from a fixed
//             address-to-data function held in the bench.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        icache_en_i;
  logic [31:0] iphy_addr_i;
  logic        invalidate_i;
  logic [31:0] icache_data_o;
  logic        icache_data_ready_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        mem_data_ready_i;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  icache #(.LINES(16), .WORDS(4)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .icache_en_i         (icache_en_i),
    .iphy_addr_i         (iphy_addr_i),
    .invalidate_i        (invalidate_i),
    .icache_data_o       (icache_data_o),
    .icache_data_ready_o (icache_data_ready_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_data_i          (mem_data_i),
    .mem_data_ready_i    (mem_data_ready_i),
    .busy_o              (busy_o)
  );

  // Backing-memory contents: distinct, address-dependent words.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Serves refill words first..last of the line at base. Word stall_word is
  // preceded by stall_n cycles with mem_data_ready_i low; invalidate_i pulses
  // in the cycle that completes word inval_word.
  task automatic serve(input logic [31:0] base, input int first, input int last,
                       input int stall_word, input int stall_n, input int inval_word);
    for (int w = first; w <= last; w++) begin
      if (w == stall_word) begin
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk_i);
          mem_data_ready_i = 1'b0;
          invalidate_i     = 1'b0;
          #1;
          check("stall_req",  32'(mem_req_o), 32'd1);
          check("stall_addr", mem_addr_o, base + 32'(4 * w));
          check("stall_busy", 32'(busy_o), 32'd1);
        end
      end
      @(negedge clk_i);
      mem_data_ready_i = 1'b1;
      mem_data_i       = mem_word(base + 32'(4 * w));
      invalidate_i     = (w == inval_word);
      #1;
      check("refill_req",  32'(mem_req_o), 32'd1);
      check("refill_addr", mem_addr_o, base + 32'(4 * w));
      check("refill_rdy",  32'(icache_data_ready_o), 32'd0);
      check("refill_data", icache_data_o, 32'd0);
    end
  endtask

  // The cycle after the last word: DONE.
  task automatic expect_done();
    @(negedge clk_i);
    mem_data_ready_i = 1'b0;
    invalidate_i     = 1'b0;
    #1;
    check("done_req",  32'(mem_req_o), 32'd0);
    check("done_rdy",  32'(icache_data_ready_o), 32'd0);
    check("done_busy", 32'(busy_o), 32'd1);
  endtask

  // Back in IDLE: the held fetch address must hit.
  task automatic expect_hit(input logic [31:0] addr);
    @(negedge clk_i);
    #1;
    check("hit_rdy",  32'(icache_data_ready_o), 32'd1);
    check("hit_data", icache_data_o, mem_word(addr));
    check("hit_busy", 32'(busy_o), 32'd0);
  endtask

  // Present a fetch in the current (post-negedge) window and expect a miss.
  task automatic present_miss(input logic [31:0] addr);
    icache_en_i = 1'b1;
    iphy_addr_i = addr;
    #1;
    check("miss_rdy", 32'(icache_data_ready_o), 32'd0);
    check("miss_req", 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    rst_i            = 1'b0;
    icache_en_i      = 1'b0;
    iphy_addr_i      = '0;
    invalidate_i     = 1'b0;
    mem_data_i       = '0;
    mem_data_ready_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_req",  32'(mem_req_o), 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_rdy",  32'(icache_data_ready_o), 32'd0);
    check("rst_data", icache_data_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Cold miss on 0x1004
    @(negedge clk_i);
    present_miss(32'h0000_1004);
    serve(32'h0000_1000, 0, 3, -1, 0, -1);
    expect_done();
    expect_hit(32'h0000_1004);

    // Same-cycle hit on 0x100C, no bus activity
    iphy_addr_i = 32'h0000_100C;
    #1;
    check("hit2_rdy",  32'(icache_data_ready_o), 32'd1);
    check("hit2_data", icache_data_o, mem_word(32'h0000_100C));
    check("hit2_req",  32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    #1;
    check("hit2_busy", 32'(busy_o), 32'd0);

    // Conflict: 0x2004 maps to index 0 with another tag
    present_miss(32'h0000_2004);
    serve(32'h0000_2000, 0, 3, -1, 0, -1);
    expect_done();
    expect_hit(32'h0000_2004);

    // 0x1004 was evicted; refill with word 2 stalled for 5 cycles
    present_miss(32'h0000_1004);
    serve(32'h0000_1000, 0, 3, 2, 5, -1);
    expect_done();
    expect_hit(32'h0000_1004);

    // Invalidate during word 1 of a refill of 0x4050 (index 5)
    present_miss(32'h0000_4050);
    serve(32'h0000_4050, 0, 3, -1, 0, 1);
    expect_done();
    @(negedge clk_i);
    #1;
    check("inval_retry_rdy", 32'(icache_data_ready_o), 32'd0);
    serve(32'h0000_4050, 0, 3, -1, 0, -1);
    expect_done();
    expect_hit(32'h0000_4050);

    // The invalidate also dropped the 0x1000 line
    iphy_addr_i = 32'h0000_1004;
    #1;
    check("inval_old_rdy", 32'(icache_data_ready_o), 32'd0);
    icache_en_i = 1'b0;
    #1;
    check("en_off_rdy", 32'(icache_data_ready_o), 32'd0);
    @(negedge clk_i);
    #1;
    check("en_off_busy", 32'(busy_o), 32'd0);
    check("en_off_req",  32'(mem_req_o), 32'd0);

    // Reset during word 2 of a refill of 0x5000
    present_miss(32'h0000_5000);
    serve(32'h0000_5000, 0, 1, -1, 0, -1);
    @(negedge clk_i);
    mem_data_ready_i = 1'b0;
    #1;
    check("pre_rst_req",  32'(mem_req_o), 32'd1);
    check("pre_rst_addr", mem_addr_o, 32'h0000_5008);
    rst_i = 1'b0;
    #1;
    check("mid_rst_req",  32'(mem_req_o), 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    #1;
    check("rst_hold_req", 32'(mem_req_o), 32'd0);
    rst_i = 1'b1;
    #1;
    check("post_rst_rdy", 32'(icache_data_ready_o), 32'd0);
    serve(32'h0000_5000, 0, 3, -1, 0, -1);
    expect_done();
    expect_hit(32'h0000_5000);

    icache_en_i = 1'b0;
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_icache
`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of two).
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 icache_en_i  input  1  fetch request from MMU (cacheable instruction access).
REQ-006 iphy_addr_i  input  32  physical fetch address from MMU; bits [1:0] ignored.
REQ-007 invalidate_i  input  1  single-cycle pulse; invalidate entire cache.
REQ-008 icache_data_o  output  32  fetched instruction word.
REQ-009 icache_data_ready_o  output  1  icache_data_o valid for the current iphy_addr_i.
REQ-010 mem_req_o  output  1  refill read request to memory bus.
REQ-011 mem_addr_o  output  32  word-aligned refill address.
REQ-012 mem_data_i  input  32  refill read data.
REQ-013 mem_data_ready_i  input  1  mem_data_i valid; completes the current request.
REQ-014 busy_o  output  1  high while state is not IDLE.

Function
REQ-015 Address split (defaults): offset [3:2], index [7:4], tag [31:8]; widths follow LINES/WORDS.
REQ-016 Storage: per line one valid bit, one tag, WORDS data words; all held in registers.
REQ-017 FSM states: IDLE, REFILL, DONE.
REQ-018 IDLE, icache_en_i=1, valid[index] and tag match: hit; icache_data_ready_o=1 and icache_data_o=word[index][offset] combinationally, same cycle (zero latency).
REQ-019 IDLE, icache_en_i=1, miss: icache_data_ready_o=0; latch line base address (offset zeroed), clear word counter, go to REFILL next cycle.
REQ-020 REFILL: mem_req_o=1, mem_addr_o=base+4*counter; request held stable until mem_data_ready_i.
REQ-021 REFILL, mem_data_ready_i=1: write mem_data_i into word[counter]; counter increments; on counter=WORDS-1 write tag, set valid (unless REQ-026), go to DONE.
REQ-022 Words fetched strictly in order 0..WORDS-1; no critical-word-first; one request per word.
REQ-023 DONE: one cycle, mem_req_o=0, icache_data_ready_o=0; then IDLE, where the retried access hits.
REQ-024 icache_data_ready_o=0 in REFILL and DONE regardless of address; icache_data_o=0 whenever ready is 0.
REQ-025 icache_en_i deasserted or iphy_addr_i changed mid-refill: refill completes using latched address; new address evaluated in IDLE.
REQ-026 invalidate_i in IDLE: all valid bits cleared next edge; a same-cycle hit still reports ready. invalidate_i in REFILL/DONE: all valid bits cleared and the line being refilled is left invalid on completion.
REQ-027 mem_data_ready_i outside REFILL ignored.
REQ-028 icache_en_i=0 in IDLE: no state change, ready=0.

Reset
REQ-029 On rst_i low, immediately: state IDLE, all valid bits 0, counter 0, mem_req_o 0, mem_addr_o 0, icache_data_ready_o 0, icache_data_o 0, busy_o 0.
REQ-030 Reset mid-refill abandons the refill; the partially filled line is invalid; no further mem_req_o until a new miss.
REQ-031 Tag and data arrays need not be reset.

Structure
REQ-032 State encoding and address field width constants live in the shared core package, reused by the later data cache.
REQ-033 Single module; no sub-modules; the tag/data arrays are inline register arrays.

Verification
REQ-034 Cold miss: after reset, fetch 0x0000_1004 -> mem_addr_o 0x1000,0x1004,0x1008,0x100C in order, one DONE cycle, then ready=1 with word at 0x1004.
REQ-035 Hit: after REQ-034, fetch 0x0000_100C -> ready=1 in the same cycle, mem_req_o stays 0.
REQ-036 Conflict: fetch 0x0000_2004 (same index 0, tag differs) -> refill from 0x2000; subsequent fetch 0x1004 misses again.
REQ-037 Stalled bus: mem_data_ready_i held low 5 cycles on word 2 -> mem_req_o and mem_addr_o 0x1008 stable throughout; busy_o=1.
REQ-038 invalidate_i pulsed during word 1 of refill -> refill finishes, retry of same address misses and refills again.
REQ-039 rst_i low during word 2 of refill -> mem_req_o drops immediately; after release, fetch of that address triggers full refill.
